// File: rtl/timer_scheduler_if.sv
// Requester-side bundle for timer_scheduler: requests, delays, ack in; grant/status out.
// Master drives requests and ack; slave is the scheduler.
interface timer_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_delay;
  logic                 ack;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        owner_id;
  logic [3:0]           count;
  logic                 counting;
  logic                 done;

  modport master (
    output req, req_delay, ack,
    input  grant, owner_id, count, counting, done
  );

  modport slave (
    input  req, req_delay, ack,
    output grant, owner_id, count, counting, done
  );
endinterface

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one (delay+1)*UNIT_CYCLES timer among NUM_REQ requesters.
// Optional TIMER_SCHED_ABORT_EN: owner dropping req during COUNT aborts the timer.
//
// state    | meaning
// ST_IDLE  | no owner; grant the next requester in round-robin order
// ST_COUNT | timer running for the owner
// ST_DONE  | timer expired; holding grant until ack
module timer_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int UNIT_CYCLES = 1000
) (
  input logic               clk,
  input logic               reset,
  timer_scheduler_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DONE} state_t;

  state_t             r_state,    w_state;
  logic [NUM_REQ-1:0] r_grant,    w_grant;
  logic [IW-1:0]      r_owner,    w_owner;
  logic [3:0]         r_count,    w_count;
  logic               r_counting, w_counting;
  logic               r_done,     w_done;
  logic [UW-1:0]      r_unit,     w_unit;

  logic               w_win_hit;
  logic [IW-1:0]      w_win;
  logic [3:0]         w_win_delay;

  // r_owner doubles as last-owner: it only changes on a new grant, so in
  // IDLE it always holds the previous owner and the scan starts just past it.
  always_comb begin
    logic [IW-1:0] v_idx;
    v_idx       = '0;
    w_win_hit   = 1'b0;
    w_win       = '0;
    w_win_delay = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      v_idx = IW'((int'(r_owner) + k) % NUM_REQ);
      if (!w_win_hit && bus.req[v_idx]) begin
        w_win_hit = 1'b1;
        w_win     = v_idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i)) w_win_delay = bus.req_delay[4*i +: 4];
    end
  end

  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_owner    = r_owner;
    w_count    = r_count;
    w_counting = r_counting;
    w_done     = r_done;
    w_unit     = r_unit;
    case (r_state)
      ST_IDLE: begin
        w_count = '0;
        if (w_win_hit) begin
          w_grant    = NUM_REQ'(1) << w_win;
          w_owner    = w_win;
          w_count    = w_win_delay;
          w_unit     = '0;
          w_counting = 1'b1;
          w_state    = ST_COUNT;
        end
      end
      ST_COUNT: begin
`ifdef TIMER_SCHED_ABORT_EN
        if (!bus.req[r_owner]) begin
          w_grant    = '0;
          w_counting = 1'b0;
          w_count    = '0;
          w_unit     = '0;
          w_state    = ST_IDLE;
        end else
`endif
        if (r_unit == UW'(UNIT_CYCLES - 1)) begin
          w_unit = '0;
          if (r_count == 4'd0) begin
            w_counting = 1'b0;
            w_done     = 1'b1;
            w_state    = ST_DONE;
          end else begin
            w_count = r_count - 4'd1;
          end
        end else begin
          w_unit = r_unit + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.ack) begin
          w_done  = 1'b0;
          w_grant = '0;
          w_state = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_owner    <= IW'(NUM_REQ - 1);
      r_count    <= '0;
      r_counting <= 1'b0;
      r_done     <= 1'b0;
      r_unit     <= '0;
    end else begin
      r_state    <= w_state;
      r_grant    <= w_grant;
      r_owner    <= w_owner;
      r_count    <= w_count;
      r_counting <= w_counting;
      r_done     <= w_done;
      r_unit     <= w_unit;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.owner_id = r_owner;
  assign bus.count    = r_count;
  assign bus.counting = r_counting;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios then random traffic against a cycle-count model.
// Expectations follow TIMER_SCHED_ABORT_EN when it is defined for the build.
module tb_timer_scheduler;
  localparam int N = 4;
  localparam int U = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  timer_scheduler_if #(.NUM_REQ(N)) bus ();
  timer_scheduler #(.NUM_REQ(N), .UNIT_CYCLES(U)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 counting, 2 waiting for ack; m_left = counting cycles still to run.
  int m_phase = 0;
  int m_left  = 0;
  int m_owner = N - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    case (m_phase)
      0: if (bus.req != '0) begin
        bit found = 0;
        int d;
        for (int k = 1; k <= N; k++) begin
          int i = (m_owner + k) % N;
          if (!found && bus.req[i]) begin
            found = 1;
            m_owner = i;
          end
        end
        d = int'(bus.req_delay[4*m_owner +: 4]);
        m_left  = (d + 1) * U;
        m_phase = 1;
      end
      1: begin
        bit ab = 0;
`ifdef TIMER_SCHED_ABORT_EN
        ab = !bus.req[m_owner];
`endif
        if (ab) m_phase = 0;
        else begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
      end
      default: if (bus.ack) m_phase = 0;
    endcase
  endtask

  task automatic check_all();
    int eg, ec;
    eg = (m_phase != 0) ? (1 << m_owner) : 0;
    ec = (m_phase == 1) ? (m_left - 1) / U : 0;
    chk("grant",    32'(bus.grant),    eg);
    chk("owner_id", 32'(bus.owner_id), m_owner);
    chk("count",    32'(bus.count),    ec);
    chk("counting", 32'(bus.counting), (m_phase == 1) ? 1 : 0);
    chk("done",     32'(bus.done),     (m_phase == 2) ? 1 : 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    m_phase = 0;
    m_left  = 0;
    m_owner = N - 1;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_done(input int bound, output int ncyc);
    ncyc = 0;
    for (int i = 0; i < bound && !bus.done; i++) begin
      if (bus.counting) ncyc++;
      tick();
    end
    chk("done_timeout", 32'(bus.done), 1);
  endtask

  task automatic ack_now();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  initial begin
    int n, m;
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = '0;
    bus.req_delay = '0;
    bus.ack = 1'b0;
    #2;
    do_reset();
    chk("rst_owner", 32'(bus.owner_id), 3);
    chk("rst_grant", 32'(bus.grant), 0);

    // 1: single requester, delay 2
    bus.req = 4'b0001;
    bus.req_delay = 16'h0002;
    tick();
    chk("s1_grant", 32'(bus.grant), 4'b0001);
    chk("s1_count0", 32'(bus.count), 2);
    bus.req = '0;
    wait_done(100, n);
    chk("s1_cycles", n, 12);
    tick();
    tick();
    chk("s1_done_hold", 32'(bus.done), 1);
    ack_now();
    chk("s1_ack_grant", 32'(bus.grant), 0);

    // 2: two requesters after reset, requester 0 first, one idle cycle between owners
    do_reset();
    bus.req = 4'b0101;
    bus.req_delay = 16'h0000;
    tick();
    chk("s2_first", 32'(bus.grant), 4'b0001);
    wait_done(100, n);
    chk("s2_cycles", n, 4);
    ack_now();
    chk("s2_gap", 32'(bus.grant), 0);
    tick();
    chk("s2_second", 32'(bus.grant), 4'b0100);
    chk("s2_owner", 32'(bus.owner_id), 2);
    wait_done(100, n);
    ack_now();

    // 3: all requesting, rotation order
    do_reset();
    bus.req = 4'b1111;
    bus.req_delay = 16'h1021;
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("s3_order", 32'(bus.grant), 32'(order[r]));
      wait_done(200, n);
      ack_now();
    end
    bus.req = '0;

    // 4: ack during COUNT ignored, delay 15; then async reset mid-count
    do_reset();
    bus.req = 4'b0001;
    bus.req_delay = 16'h000F;
    tick();
    bus.req = '0;
    n = 0;
    for (int i = 0; i < 300 && !bus.done; i++) begin
      bus.ack = (i % 7 == 3);
      if (bus.counting) n++;
      tick();
    end
    bus.ack = 1'b0;
    chk("s4_cycles", n, 64);
    ack_now();
    bus.req = 4'b0010;
    bus.req_delay = 16'h0050;
    tick();
    tick();
    tick();
    do_reset();
    chk("s4_rst_grant", 32'(bus.grant), 0);
    chk("s4_rst_counting", 32'(bus.counting), 0);
    bus.req = 4'b1000;
    tick();
    chk("s4_after_rst", 32'(bus.grant), 4'b1000);
    bus.req = '0;
    wait_done(300, n);
    ack_now();

    // 5: owner drops req mid-count
    do_reset();
    bus.req = 4'b0010;
    bus.req_delay = 16'h0030;
    tick();
    chk("s5_grant", 32'(bus.grant), 4'b0010);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.counting) n++;
      tick();
    end
    bus.req = 4'b0100;
`ifdef TIMER_SCHED_ABORT_EN
    tick();
    chk("s5_abort_grant", 32'(bus.grant), 0);
    chk("s5_abort_done", 32'(bus.done), 0);
    bus.req = 4'b0110;
    tick();
    chk("s5_next", 32'(bus.grant), 4'b0100);
    wait_done(100, m);
    ack_now();
`else
    wait_done(100, m);
    chk("s5_cycles", n + m, 16);
    ack_now();
`endif
    bus.req = '0;

    // 6: req_delay changed during COUNT is ignored
    do_reset();
    bus.req = 4'b0001;
    bus.req_delay = 16'h0002;
    tick();
    tick();
    bus.req_delay = 16'h0007;
    tick();
    n = 2;
    wait_done(100, m);
    chk("s6_cycles", n + m, 12);
    ack_now();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req_delay = 16'($urandom) & 16'h7373;
      bus.ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 699) == 0) do_reset();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
